// File: rtl/ocp_slave_mem.sv
// Memory-backed OCP slave: single-beat RD/WR commands, one outstanding
// command at a time, a programmable accept latency, and DVA/ERR responses.
module ocp_slave_mem #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int ACCEPT_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          MCmd,
    input  logic [ADDR_W-1:0]   MAddr,
    input  logic [DATA_W-1:0]   MData,
    input  logic [DATA_W/8-1:0] MByteEn,
    output logic                SCmdAccept,
    input  logic                MRespAccept,
    output logic [1:0]          SResp,
    output logic [DATA_W-1:0]   SData
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OCP_IDLE = 3'd0;
    localparam logic [2:0] OCP_WR   = 3'd1;
    localparam logic [2:0] OCP_RD   = 3'd2;

    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic {CMD, RESP} state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          wcnt;
    logic [1:0]          resp_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   word_index;
    logic [IDX_W-1:0]    widx;
    logic                bad;
    logic                accept;
    logic                resp_done;

    // Request decode: word index, memory index and bad-request detection
    always_comb begin
        word_index = MAddr >> OFF_W;
        widx       = MAddr[OFF_W +: IDX_W];
        bad        = (MAddr[OFF_W-1:0] != '0)
                   || (word_index >= ADDR_W'(DEPTH))
                   || ((MCmd != OCP_WR) && (MCmd != OCP_RD));
    end

    // Next-state logic and combinational accept
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        resp_done  = 1'b0;
        case (state)
            CMD: begin
                if ((MCmd != OCP_IDLE) && (wcnt == 4'(ACCEPT_LAT))) begin
                    accept     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (MRespAccept) begin
                    resp_done  = 1'b1;
                    state_next = CMD;
                end
            end
            default: state_next = CMD;
        endcase
        SCmdAccept = accept;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CMD;
        else     state <= state_next;
    end

    // Accept-latency counter; only counts while a command waits in CMD
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= '0;
        else if ((state != CMD) || (MCmd == OCP_IDLE) || accept)
            wcnt <= '0;
        else if (wcnt != 4'(ACCEPT_LAT))
            wcnt <= wcnt + 4'd1;
    end

    // Registered response and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= RESP_NULL;
            data_q <= '0;
        end else if (accept) begin
            if (bad) begin
                resp_q <= RESP_ERR;
                data_q <= '0;
            end else begin
                resp_q <= RESP_DVA;
                if (MCmd == OCP_RD) data_q <= mem[widx];
            end
        end else if (resp_done) begin
            resp_q <= RESP_NULL;
        end
    end

    // Memory array: cleared on reset, byte-masked write on a good WR accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accept && !bad && (MCmd == OCP_WR)) begin
            for (int unsigned b = 0; b < BYTES; b++)
                if (MByteEn[b]) mem[widx][b*8 +: 8] <= MData[b*8 +: 8];
        end
    end

    assign SResp = resp_q;
    assign SData = data_q;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Self-checking bench for ocp_slave_mem: two instances (accept latency 0 and 3)
// compared every cycle against a word-array model of the memory and responses.
module tb_ocp_slave_mem;

    logic        clk = 1'b0;
    logic        rst;

    logic [2:0]  mcmd  [2];
    logic [31:0] maddr [2];
    logic [31:0] mdata [2];
    logic [3:0]  mbe   [2];
    logic        mra   [2];
    logic        acc   [2];
    logic [1:0]  sresp [2];
    logic [31:0] sdata [2];

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_resp [2];
    logic [31:0] exp_data [2];
    logic        exp_acc  [2];
    logic [31:0] mdl [2][256];
    int          issued   [2];
    int          acc_seen [2];
    int          resp_seen[2];
    logic [1:0]  prev_resp[2];

    always #5 clk = ~clk;

    ocp_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .ACCEPT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .MCmd(mcmd[0]), .MAddr(maddr[0]), .MData(mdata[0]),
        .MByteEn(mbe[0]), .SCmdAccept(acc[0]), .MRespAccept(mra[0]),
        .SResp(sresp[0]), .SData(sdata[0])
    );

    ocp_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .ACCEPT_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .MCmd(mcmd[1]), .MAddr(maddr[1]), .MData(mdata[1]),
        .MByteEn(mbe[1]), .SCmdAccept(acc[1]), .MRespAccept(mra[1]),
        .SResp(sresp[1]), .SData(sdata[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("sresp%0d", d), 32'(sresp[d]), 32'(exp_resp[d]));
            chk($sformatf("sdata%0d", d), sdata[d], exp_data[d]);
            chk($sformatf("accept%0d", d), 32'(acc[d]), 32'(exp_acc[d]));
            if (acc[d] === 1'b1) acc_seen[d]++;
            if (sresp[d] != 2'd0 && prev_resp[d] == 2'd0) resp_seen[d]++;
            prev_resp[d] = sresp[d];
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) mdl[d][i] = '0;
            exp_resp[d] = 2'd0;
            exp_data[d] = '0;
            exp_acc[d]  = 1'b0;
        end
    endtask

    // Present a command, hold it until the expected accept edge, apply the model.
    // Called and returns at 1 time unit after a rising edge.
    task automatic issue(input int d, input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        int  lat = (d == 0) ? 0 : 3;
        bit  bad;
        int  idx;
        mcmd[d] = cmd; maddr[d] = addr; mdata[d] = data; mbe[d] = be;
        for (int k = 0; k <= lat; k++) begin
            exp_acc[d] = (k == lat);
            @(posedge clk); #1;
        end
        issued[d]++;
        idx = int'(addr >> 2);
        bad = (addr % 4 != 0) || (addr / 4 >= 256) || !(cmd == 3'd1 || cmd == 3'd2);
        if (bad) begin
            exp_resp[d] = 2'd3;
            exp_data[d] = '0;
        end else begin
            exp_resp[d] = 2'd1;
            if (cmd == 3'd1) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[d][idx][b*8 +: 8] = data[b*8 +: 8];
            end else begin
                exp_data[d] = mdl[d][idx];
            end
        end
        mcmd[d] = 3'd0;
        exp_acc[d] = 1'b0;
    endtask

    task automatic finish_resp(input int d, input int delay);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        mra[d] = 1'b1;
        @(posedge clk); #1;
        mra[d] = 1'b0;
        exp_resp[d] = 2'd0;
    endtask

    task automatic op(input int d, input logic [2:0] cmd, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be, input int delay);
        issue(d, cmd, addr, data, be);
        finish_resp(d, delay);
    endtask

    task automatic rand_op(input int d);
        logic [2:0]  cmd;
        logic [31:0] addr;
        int          r   = int'($urandom_range(0, 19));
        int          sel = int'($urandom_range(0, 15));
        if (r < 9)       cmd = 3'd1;
        else if (r < 18) cmd = 3'd2;
        else             cmd = 3'($urandom_range(3, 7));
        if (sel == 0)      addr = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
        else if (sel == 1) addr = 32'h400 + $urandom_range(0, 255) * 4;
        else               addr = $urandom_range(0, 15) * 4;
        op(d, cmd, addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mcmd[d] = 3'd0; maddr[d] = '0; mdata[d] = '0; mbe[d] = '0; mra[d] = 1'b0;
            issued[d] = 0; acc_seen[d] = 0; resp_seen[d] = 0; prev_resp[d] = 2'd0;
        end
        clear_model();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_sresp", 32'(sresp[0]), 32'd0);
        chk("reset_sdata", sdata[0], 32'd0);
        rst = 1'b0;

        // Basic write then read, latency 0
        op(0, 3'd1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        issue(0, 3'd2, 32'h10, 32'h0, 4'h0);
        chk("rd10_resp", 32'(sresp[0]), 32'd1);
        chk("rd10_data", sdata[0], 32'hDEADBEEF);
        finish_resp(0, 0);

        // Byte-enable merge
        op(0, 3'd1, 32'h20, 32'h11223344, 4'hF, 0);
        op(0, 3'd1, 32'h20, 32'hAABBCCDD, 4'h5, 1);
        issue(0, 3'd2, 32'h20, 32'h0, 4'h0);
        chk("rd20_merge", sdata[0], 32'h11BB33DD);
        finish_resp(0, 0);

        // Bad requests: misaligned, out of range, unsupported command
        issue(0, 3'd2, 32'h22, 32'h0, 4'h0);
        chk("misalign_resp", 32'(sresp[0]), 32'd3);
        chk("misalign_data", sdata[0], 32'd0);
        finish_resp(0, 0);
        issue(0, 3'd2, 32'h400, 32'h0, 4'h0);
        chk("range_resp", 32'(sresp[0]), 32'd3);
        finish_resp(0, 0);
        issue(0, 3'd5, 32'h10, 32'h12345678, 4'hF);
        chk("badcmd_resp", 32'(sresp[0]), 32'd3);
        finish_resp(0, 2);
        issue(0, 3'd2, 32'h10, 32'h0, 4'h0);
        chk("rd10_after_err", sdata[0], 32'hDEADBEEF);
        finish_resp(0, 0);

        // Latency 3: abandoned command, then held response
        op(1, 3'd1, 32'h10, 32'hCAFEF00D, 4'hF, 0);
        mcmd[1] = 3'd1; maddr[1] = 32'h10; mdata[1] = 32'h0; mbe[1] = 4'hF;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mcmd[1] = 3'd0;
        @(posedge clk); #1;
        issue(1, 3'd2, 32'h10, 32'h0, 4'h0);
        chk("lat3_rd10", sdata[1], 32'hCAFEF00D);
        finish_resp(1, 5);

        // Asynchronous reset while a DVA is pending
        issue(0, 3'd2, 32'h10, 32'h0, 4'h0);
        chk("pre_rst_resp", 32'(sresp[0]), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        clear_model();
        #1;
        chk("rst_async_sresp", 32'(sresp[0]), 32'd0);
        chk("rst_async_accept", 32'(acc[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, 3'd2, 32'h10, 32'h0, 4'h0);
        chk("post_rst_rd10", sdata[0], 32'd0);
        finish_resp(0, 0);
        issue(1, 3'd2, 32'h10, 32'h0, 4'h0);
        chk("post_rst_lat3_rd10", sdata[1], 32'd0);
        finish_resp(1, 0);

        // Randomized streams
        for (int i = 0; i < 1000; i++) rand_op(0);
        for (int i = 0; i < 200; i++) rand_op(1);

        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("accept_count%0d", d), 32'(acc_seen[d]), 32'(issued[d]));
            chk($sformatf("resp_count%0d", d), 32'(resp_seen[d]), 32'(issued[d]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
